aggregation_block: RTL and testbench
====================================

Name: aggregation_block

Overview:
Downstream neighbour of the transformation stage. It walks the graph edge list (COO format) stored in shared memory, fetches each source node's transformed row (feature × weight product) from the FM_WM product memory, and sums that row into the destination node's accumulator. When all edges are processed, it streams the aggregated rows to the FM_AGG memory and pulses done. This gives the A·(X·W) step of the GCN layer.

Parameters:
NUM_NODES, 6, node count; also the FM_WM row count.
NUM_EDGES, 6, number of COO entries.
FM_WM_COLS, 3, columns per transformed row.
DOT_PROD_WIDTH, 16, element width of the FM_WM rows.
AGG_WIDTH, 19, accumulator and output element width; must be ≥ DOT_PROD_WIDTH.
COO_IDX_WIDTH, 8, width of one node index in a COO entry.
COO_BASE_ADDR, 13'h0400, shared-memory address of COO entry 0.

Ports:
clk  in  1  clock; all logic on the rising edge.
reset  in  1  synchronous, active-low reset.
start  in  1  one-cycle request; sampled only in IDLE.
enable_read  out  1  COO read strobe to shared memory.
read_address  out  13  COO address; equals COO_BASE_ADDR + edge_idx.
coo_in  in  2*COO_IDX_WIDTH  COO entry, {dst, src}; valid the cycle after enable_read.
fm_read_en  out  1  FM_WM memory read strobe.
fm_read_row  out  $clog2(NUM_NODES)  FM_WM row index.
fm_wm_row_in  in  DOT_PROD_WIDTH × [0:FM_WM_COLS-1]  row data; valid the cycle after fm_read_en.
agg_wr_en  out  1  FM_AGG write strobe.
agg_write_row  out  $clog2(NUM_NODES)  FM_AGG row index.
agg_row_out  out  AGG_WIDTH × [0:FM_WM_COLS-1]  aggregated row.
busy  out  1  high in every state except IDLE.
edge_error  out  1  sticky out-of-range-index flag.
done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (reset==0 at a clk edge), including mid-run:
  - state goes to IDLE; edge_idx, node_idx and all accumulators are cleared.
  - Every output is 0: enable_read, read_address, fm_read_en, fm_read_row, agg_wr_en, agg_write_row, agg_row_out, busy, edge_error, done.
- Outputs are Moore outputs decoded from registered state and counters.
- States and transitions:
  - IDLE: if start, go to CLR; start in any other state is ignored.
  - CLR (1 cycle): zero all accumulators, edge_idx=0, clear edge_error, go to COO_REQ.
  - COO_REQ: enable_read=1, read_address=COO_BASE_ADDR+edge_idx, go to COO_CAP.
  - COO_CAP: latch src/dst from coo_in; drive fm_read_en=1, fm_read_row=src[...]; go to FM_CAP.
  - FM_CAP: latch fm_wm_row_in, go to ACC.
  - ACC:
    - If src<NUM_NODES and dst<NUM_NODES: acc[dst][c] += zero-extended row[c] for every c, unsigned, wrapping modulo 2^AGG_WIDTH.
    - Otherwise: no update, set edge_error.
    - Then edge_idx++; go to COO_REQ, or to WRITE when edge_idx was the last edge.
  - WRITE (NUM_NODES cycles): agg_wr_en=1, agg_write_row=node_idx, agg_row_out=acc[node_idx]; node_idx counts 0..NUM_NODES-1, then go to DONE.
  - DONE (1 cycle): done=1, then IDLE. edge_error holds until the next CLR.
- Timing: each edge costs 4 cycles. With start sampled at edge T, done is high in cycle T+2+4·E+N, where E = edges processed and N = NUM_NODES.
- Boundary cases:
  - Duplicate edges accumulate twice.
  - A node with no incoming edge writes an all-zero row.
  - NUM_EDGES=0 is illegal; the parameter is checked at elaboration.

Optional Feature:
SELF_LOOP_EN
- Defined: after the NUM_EDGES COO edges, NUM_NODES virtual edges i→i are processed (A+I).
  - Each virtual edge keeps the 4-cycle timing.
  - In COO_REQ of a virtual edge, enable_read stays 0 and read_address holds its last value.
  - src=dst=edge_idx−NUM_EDGES; no COO read occurs.
  - E = NUM_EDGES+NUM_NODES.
- Undefined: only COO edges are processed.

Decomposition:
- Package gnn_agg_pkg holds:
  - the agg_state_t enum (IDLE, CLR, COO_REQ, COO_CAP, FM_CAP, ACC, WRITE, DONE);
  - localparams NODE_IDX_W=$clog2(NUM_NODES) and ADDR_W=13;
  - the default COO_BASE_ADDR.
- One sub-module, agg_accumulator_bank: an NUM_NODES×FM_WM_COLS register array with clear, add-row-at-index and read-row-at-index ports.
- The FSM and counters stay in the top module.

Test Plan:
1. Basic run. COO {(0→1),(1→2),(2→0),(3→1),(4→5),(5→4)}, FM row r = {r, 10r, 100r} → rows written:
   - row0={2,20,200}, row1={3,30,300}, row2={1,10,100}, row3=0, row4={5,50,500}, row5={4,40,400};
   - done in cycle T+32.
2. Out-of-range edge: edge 2 = {dst=7, src=0} → edge_error=1 after ACC of edge 2; rows unaffected by that edge; edge_error clears at the next start.
3. Start during operation: a start pulse during COO_REQ of edge 3 → ignored; exactly 6 WRITE cycles and one done pulse.
4. Reset mid-run: reset=0 during WRITE of row 2 → next cycle all outputs are 0 and state is IDLE; a following start gives correct results again.
5. Wrap: all edges → node 0, row values 16'hFFFF, with AGG_WIDTH=17 → acc = 6·65535 mod 2^17 = 0x5FFFA mod 2^17 = 0x1FFFA.
6. SELF_LOOP_EN, graph from test 1 → each row adds its own value (row3={3,30,300}); done in cycle T+56.

Source files
------------

// File: rtl/gnn_agg_pkg.sv
// -----------------------------------------------------------------------------
// gnn_agg_pkg
// Shared definitions for the GCN aggregation stage (A * (X * W)).
//   agg_state_t           : FSM states of aggregation_block
//   NODE_IDX_W            : node-index width for the default node count
//   ADDR_W                : shared-memory address width
//   COO_BASE_ADDR_DEFAULT : shared-memory address of COO entry 0
// -----------------------------------------------------------------------------
package gnn_agg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        COO_REQ,
        COO_CAP,
        FM_CAP,
        ACC,
        WRITE,
        DONE
    } agg_state_t;

    localparam int NUM_NODES_DEFAULT = 6;
    localparam int NODE_IDX_W        = $clog2(NUM_NODES_DEFAULT);
    localparam int ADDR_W            = 13;

    localparam logic [ADDR_W-1:0] COO_BASE_ADDR_DEFAULT = 13'h0400;

endpackage : gnn_agg_pkg

// File: rtl/agg_accumulator_bank.sv
// -----------------------------------------------------------------------------
// agg_accumulator_bank
// NUM_NODES x COLS array of unsigned accumulators. One row can be added to per
// cycle (zero-extended input, wrapping modulo 2^ACC_W) and one row is read
// combinationally.
// Ports:
//   clk        : clock, rising edge
//   reset      : synchronous active-low reset, clears every accumulator
//   clear_i    : synchronous clear of every accumulator
//   add_en_i   : add add_row_i into row add_idx_i
//   add_idx_i  : destination row of the add
//   add_row_i  : row to add, IN_W bits per element
//   rd_idx_i   : row to read
//   rd_row_o   : contents of row rd_idx_i (0 for an index past NUM_NODES-1)
// -----------------------------------------------------------------------------
module agg_accumulator_bank
    import gnn_agg_pkg::*;
#(
    parameter int NUM_NODES = 6,
    parameter int COLS      = 3,
    parameter int IN_W      = 16,
    parameter int ACC_W     = 19
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear_i,
    input  logic                          add_en_i,
    input  logic [$clog2(NUM_NODES)-1:0]  add_idx_i,
    input  logic [IN_W-1:0]               add_row_i [COLS],
    input  logic [$clog2(NUM_NODES)-1:0]  rd_idx_i,
    output logic [ACC_W-1:0]              rd_row_o  [COLS]
);

    localparam int IDX_W = $clog2(NUM_NODES);

    logic [ACC_W-1:0] acc_q [NUM_NODES][COLS];

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the values from before the clock edge.
    // NOTE: this array is built from flops, not a RAM macro, so it can and must
    // be cleared by reset; a RAM-backed store would be cleared by walking it.
    always_ff @(posedge clk) begin
        if (!reset || clear_i) begin
            for (int n = 0; n < NUM_NODES; n++) begin
                for (int c = 0; c < COLS; c++) begin
                    acc_q[n][c] <= '0;
                end
            end
        end else if (add_en_i) begin
            for (int n = 0; n < NUM_NODES; n++) begin
                if (add_idx_i == IDX_W'(n)) begin
                    for (int c = 0; c < COLS; c++) begin
                        acc_q[n][c] <= acc_q[n][c] + ACC_W'(add_row_i[c]);
                    end
                end
            end
        end
    end

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        for (int c = 0; c < COLS; c++) begin
            rd_row_o[c] = '0;
        end
        for (int n = 0; n < NUM_NODES; n++) begin
            if (rd_idx_i == IDX_W'(n)) begin
                for (int c = 0; c < COLS; c++) begin
                    rd_row_o[c] = acc_q[n][c];
                end
            end
        end
    end

endmodule : agg_accumulator_bank

// File: rtl/aggregation_block.sv
// -----------------------------------------------------------------------------
// aggregation_block
// Walks the COO edge list in shared memory, fetches each source node's
// transformed row from the FM_WM memory and sums it into the destination
// node's accumulator. After the last edge, every accumulator row is streamed
// to the FM_AGG memory and done pulses for one cycle.
//
// Optional build macro SELF_LOOP_EN: after the COO edges, NUM_NODES virtual
// edges i->i are processed (A + I) without any COO read.
//
// Ports:
//   clk           : clock, rising edge
//   reset         : synchronous active-low reset
//   start         : one-cycle request, only honoured in IDLE
//   enable_read   : COO read strobe
//   read_address  : COO address (COO_BASE_ADDR + edge index)
//   coo_in        : COO entry {dst, src}, valid the cycle after enable_read
//   fm_read_en    : FM_WM read strobe
//   fm_read_row   : FM_WM row index
//   fm_wm_row_in  : FM_WM row, valid the cycle after fm_read_en
//   agg_wr_en     : FM_AGG write strobe
//   agg_write_row : FM_AGG row index
//   agg_row_out   : aggregated row
//   busy          : high outside IDLE
//   edge_error    : sticky out-of-range node index flag, cleared by CLR
//   done          : one-cycle completion pulse
// -----------------------------------------------------------------------------
module aggregation_block
    import gnn_agg_pkg::*;
#(
    parameter int                NUM_NODES      = 6,
    parameter int                NUM_EDGES      = 6,
    parameter int                FM_WM_COLS     = 3,
    parameter int                DOT_PROD_WIDTH = 16,
    parameter int                AGG_WIDTH      = 19,
    parameter int                COO_IDX_WIDTH  = 8,
    parameter logic [ADDR_W-1:0] COO_BASE_ADDR  = COO_BASE_ADDR_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    output logic                          enable_read,
    output logic [ADDR_W-1:0]             read_address,
    input  logic [2*COO_IDX_WIDTH-1:0]    coo_in,
    output logic                          fm_read_en,
    output logic [$clog2(NUM_NODES)-1:0]  fm_read_row,
    input  logic [DOT_PROD_WIDTH-1:0]     fm_wm_row_in [0:FM_WM_COLS-1],
    output logic                          agg_wr_en,
    output logic [$clog2(NUM_NODES)-1:0]  agg_write_row,
    output logic [AGG_WIDTH-1:0]          agg_row_out  [0:FM_WM_COLS-1],
    output logic                          busy,
    output logic                          edge_error,
    output logic                          done
);

    localparam int IDX_W = $clog2(NUM_NODES);
`ifdef SELF_LOOP_EN
    localparam int TOTAL_EDGES = NUM_EDGES + NUM_NODES;
`else
    localparam int TOTAL_EDGES = NUM_EDGES;
`endif
    localparam int EDGE_W = $clog2(TOTAL_EDGES + 1);

    generate
        if (NUM_EDGES < 1) begin : g_bad_num_edges
            $error("aggregation_block: NUM_EDGES must be at least 1");
        end
        if (AGG_WIDTH < DOT_PROD_WIDTH) begin : g_bad_agg_width
            $error("aggregation_block: AGG_WIDTH must be >= DOT_PROD_WIDTH");
        end
    endgenerate

    agg_state_t                state_q, state_d;
    logic [EDGE_W-1:0]         edge_idx_q, edge_idx_d;
    logic [IDX_W-1:0]          node_idx_q, node_idx_d;
    logic [COO_IDX_WIDTH-1:0]  src_q, src_d;
    logic [COO_IDX_WIDTH-1:0]  dst_q, dst_d;
    logic [DOT_PROD_WIDTH-1:0] row_q [FM_WM_COLS];
    logic [DOT_PROD_WIDTH-1:0] row_d [FM_WM_COLS];
    logic                      edge_error_q, edge_error_d;
    logic [ADDR_W-1:0]         raddr_q, raddr_d;

    logic                      is_virtual;
    logic [COO_IDX_WIDTH-1:0]  loop_idx;
    logic [COO_IDX_WIDTH-1:0]  src_cur;
    logic [COO_IDX_WIDTH-1:0]  dst_cur;
    logic [ADDR_W-1:0]         coo_addr;
    logic                      idx_ok;
    logic [AGG_WIDTH-1:0]      rd_row [FM_WM_COLS];

    // Edge indices past the COO list are the self-loop edges i->i.
`ifdef SELF_LOOP_EN
    assign is_virtual = (edge_idx_q >= EDGE_W'(NUM_EDGES));
    assign loop_idx   = COO_IDX_WIDTH'(edge_idx_q - EDGE_W'(NUM_EDGES));
`else
    assign is_virtual = 1'b0;
    assign loop_idx   = '0;
`endif

    // In COO_CAP the entry is consumed straight from coo_in so the FM_WM
    // request can go out in the same cycle.
    assign src_cur  = is_virtual ? loop_idx : coo_in[COO_IDX_WIDTH-1:0];
    assign dst_cur  = is_virtual ? loop_idx : coo_in[2*COO_IDX_WIDTH-1:COO_IDX_WIDTH];
    assign coo_addr = COO_BASE_ADDR + ADDR_W'(edge_idx_q);
    assign idx_ok   = (src_q < COO_IDX_WIDTH'(NUM_NODES)) &&
                      (dst_q < COO_IDX_WIDTH'(NUM_NODES));

    always_comb begin
        state_d      = state_q;
        edge_idx_d   = edge_idx_q;
        node_idx_d   = node_idx_q;
        src_d        = src_q;
        dst_d        = dst_q;
        row_d        = row_q;
        edge_error_d = edge_error_q;
        raddr_d      = raddr_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLR;
                end
            end
            CLR: begin
                edge_idx_d   = '0;
                node_idx_d   = '0;
                edge_error_d = 1'b0;
                state_d      = COO_REQ;
            end
            COO_REQ: begin
                // Virtual edges keep the previous address on the bus.
                if (!is_virtual) begin
                    raddr_d = coo_addr;
                end
                state_d = COO_CAP;
            end
            COO_CAP: begin
                src_d   = src_cur;
                dst_d   = dst_cur;
                state_d = FM_CAP;
            end
            FM_CAP: begin
                row_d   = fm_wm_row_in;
                state_d = ACC;
            end
            ACC: begin
                if (!idx_ok) begin
                    edge_error_d = 1'b1;
                end
                edge_idx_d = edge_idx_q + 1'b1;
                if (edge_idx_q == EDGE_W'(TOTAL_EDGES - 1)) begin
                    node_idx_d = '0;
                    state_d    = WRITE;
                end else begin
                    state_d = COO_REQ;
                end
            end
            WRITE: begin
                if (node_idx_q == IDX_W'(NUM_NODES - 1)) begin
                    state_d = DONE;
                end else begin
                    node_idx_d = node_idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            edge_idx_q   <= '0;
            node_idx_q   <= '0;
            src_q        <= '0;
            dst_q        <= '0;
            edge_error_q <= 1'b0;
            raddr_q      <= '0;
            for (int c = 0; c < FM_WM_COLS; c++) begin
                row_q[c] <= '0;
            end
        end else begin
            state_q      <= state_d;
            edge_idx_q   <= edge_idx_d;
            node_idx_q   <= node_idx_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            edge_error_q <= edge_error_d;
            raddr_q      <= raddr_d;
            row_q        <= row_d;
        end
    end

    agg_accumulator_bank #(
        .NUM_NODES (NUM_NODES),
        .COLS      (FM_WM_COLS),
        .IN_W      (DOT_PROD_WIDTH),
        .ACC_W     (AGG_WIDTH)
    ) u_bank (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (state_q == CLR),
        .add_en_i  ((state_q == ACC) && idx_ok),
        .add_idx_i (dst_q[IDX_W-1:0]),
        .add_row_i (row_q),
        .rd_idx_i  (node_idx_q),
        .rd_row_o  (rd_row)
    );

    // Moore outputs; every strobe and index is forced to 0 outside its state.
    assign busy          = (state_q != IDLE);
    assign enable_read   = (state_q == COO_REQ) && !is_virtual;
    assign read_address  = enable_read ? coo_addr : raddr_q;
    assign fm_read_en    = (state_q == COO_CAP);
    assign fm_read_row   = fm_read_en ? src_cur[IDX_W-1:0] : '0;
    assign agg_wr_en     = (state_q == WRITE);
    assign agg_write_row = agg_wr_en ? node_idx_q : '0;
    assign edge_error    = edge_error_q;
    assign done          = (state_q == DONE);

    always_comb begin
        for (int c = 0; c < FM_WM_COLS; c++) begin
            agg_row_out[c] = agg_wr_en ? rd_row[c] : '0;
        end
    end

endmodule : aggregation_block

// File: tb/tb_aggregation_block.sv
// -----------------------------------------------------------------------------
// tb_aggregation_block
// Directed bench for aggregation_block. Two instances share the clock: one with
// default parameters and one with AGG_WIDTH=17 for the wrap case. Shared-memory
// and FM_WM memory responders return data from the tables below. Expected rows
// are hand-derived from the graphs; with SELF_LOOP_EN each row r additionally
// receives its own FM row.
// -----------------------------------------------------------------------------
module tb_aggregation_block;

`ifdef SELF_LOOP_EN
    localparam int SL = 1;
`else
    localparam int SL = 0;
`endif
    // Posedges from the start-sampling edge to the first sample showing done:
    // CLR + 4 per edge + 6 WRITE + DONE (done in cycle T+32, or T+56 with loops).
    localparam int LAT_EXP = 4 * (6 + 6 * SL) + 6 + 1;
    localparam int MUL [0:2] = '{1, 10, 100};

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic start_w = 1'b0;

    // default instance
    logic        enable_read, fm_read_en, agg_wr_en, busy, edge_error, done;
    logic [12:0] read_address;
    logic [2:0]  fm_read_row, agg_write_row;
    logic [15:0] coo_in = '0;
    logic [15:0] fm_row [0:2] = '{16'd0, 16'd0, 16'd0};
    logic [18:0] agg_row_out [0:2];

    // AGG_WIDTH=17 instance
    logic        enable_read_w, fm_read_en_w, agg_wr_en_w, busy_w, edge_error_w, done_w;
    logic [12:0] read_address_w;
    logic [2:0]  fm_read_row_w, agg_write_row_w;
    logic [15:0] coo_in_w = '0;
    logic [15:0] fm_row_w [0:2] = '{16'd0, 16'd0, 16'd0};
    logic [16:0] agg_row_out_w [0:2];

    logic [15:0] coo_tab [0:5];
    logic [15:0] fm_tab  [0:5][0:2];

    logic [18:0] wr_rows   [0:5][0:2];
    logic [16:0] wr_rows_w [0:5][0:2];
    int wr_cnt = 0;
    int done_cnt = 0;

    int errors = 0;
    int checks = 0;

    logic [81:0] outs_flat;
    logic [75:0] outs_flat_w;
    assign outs_flat = {enable_read, read_address, fm_read_en, fm_read_row, agg_wr_en,
                        agg_write_row, agg_row_out[0], agg_row_out[1], agg_row_out[2],
                        busy, edge_error, done};
    assign outs_flat_w = {enable_read_w, read_address_w, fm_read_en_w, fm_read_row_w,
                          agg_wr_en_w, agg_write_row_w, agg_row_out_w[0], agg_row_out_w[1],
                          agg_row_out_w[2], busy_w, edge_error_w, done_w};

    always #5 clk = ~clk;

    aggregation_block dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .enable_read   (enable_read),
        .read_address  (read_address),
        .coo_in        (coo_in),
        .fm_read_en    (fm_read_en),
        .fm_read_row   (fm_read_row),
        .fm_wm_row_in  (fm_row),
        .agg_wr_en     (agg_wr_en),
        .agg_write_row (agg_write_row),
        .agg_row_out   (agg_row_out),
        .busy          (busy),
        .edge_error    (edge_error),
        .done          (done)
    );

    aggregation_block #(.AGG_WIDTH(17)) dut_w (
        .clk           (clk),
        .reset         (reset),
        .start         (start_w),
        .enable_read   (enable_read_w),
        .read_address  (read_address_w),
        .coo_in        (coo_in_w),
        .fm_read_en    (fm_read_en_w),
        .fm_read_row   (fm_read_row_w),
        .fm_wm_row_in  (fm_row_w),
        .agg_wr_en     (agg_wr_en_w),
        .agg_write_row (agg_write_row_w),
        .agg_row_out   (agg_row_out_w),
        .busy          (busy_w),
        .edge_error    (edge_error_w),
        .done          (done_w)
    );

    // Memory responders: a strobe seen mid-cycle puts the data on the bus, where
    // it stays through the following cycle in which the DUT captures it.
    always @(negedge clk) begin : mem_dut
        int ai;
        if (enable_read) begin
            ai = int'(read_address) - 'h400;
            coo_in = (ai >= 0 && ai < 6) ? coo_tab[ai] : 16'h0;
        end
        if (fm_read_en) begin
            for (int c = 0; c < 3; c++)
                fm_row[c] = (fm_read_row < 3'd6) ? fm_tab[fm_read_row][c] : 16'h0;
        end
    end

    always @(negedge clk) begin : mem_dut_w
        int ai;
        if (enable_read_w) begin
            ai = int'(read_address_w) - 'h400;
            coo_in_w = (ai >= 0 && ai < 6) ? coo_tab[ai] : 16'h0;
        end
        if (fm_read_en_w) begin
            for (int c = 0; c < 3; c++)
                fm_row_w[c] = (fm_read_row_w < 3'd6) ? fm_tab[fm_read_row_w][c] : 16'h0;
        end
    end

    // Write collectors
    always @(negedge clk) begin
        if (agg_wr_en) begin
            if (agg_write_row < 3'd6)
                for (int c = 0; c < 3; c++) wr_rows[agg_write_row][c] = agg_row_out[c];
            wr_cnt = wr_cnt + 1;
        end
        if (done) done_cnt = done_cnt + 1;
    end

    always @(negedge clk) begin
        if (agg_wr_en_w && agg_write_row_w < 3'd6)
            for (int c = 0; c < 3; c++) wr_rows_w[agg_write_row_w][c] = agg_row_out_w[c];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Graph of the basic test: src->dst (0,1),(1,2),(2,0),(3,1),(4,5),(5,4);
    // FM row r = {r, 10r, 100r}. bad_edge2 replaces edge 2 with {dst=7, src=0}.
    task automatic load_graph(input bit bad_edge2);
        int src_l [6] = '{0, 1, 2, 3, 4, 5};
        int dst_l [6] = '{1, 2, 0, 1, 5, 4};
        for (int i = 0; i < 6; i++) coo_tab[i] = {8'(dst_l[i]), 8'(src_l[i])};
        if (bad_edge2) coo_tab[2] = {8'd7, 8'd0};
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 3; c++) fm_tab[r][c] = 16'(r * MUL[c]);
    endtask

    // Leaves the bench at the sample just after the start-sampling edge (CLR).
    task automatic launch(input bit wide);
        @(negedge clk);
        if (wide) start_w = 1'b1;
        else      start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        start_w = 1'b0;
    endtask

    task automatic wait_done(input bit wide, input int budget, output int lat);
        lat = -1;
        for (int m = 0; m < budget; m++) begin
            if ((wide ? done_w : done) === 1'b1) begin
                lat = m;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (outs_flat !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", outs_flat);
        end
        checks++;
        if (outs_flat_w !== '0) begin
            errors++;
            $display("FAIL reset_outputs_w: got %h expected 0", outs_flat_w);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (outs_flat !== '0) begin
            errors++;
            $display("FAIL idle_outputs: got %h expected 0", outs_flat);
        end
    endtask

    task automatic test_basic();
        int g [6] = '{2, 3, 1, 0, 5, 4};
        int lat;
        int w0;
        int exp;
        load_graph(1'b0);
        w0 = wr_cnt;
        launch(1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: got %b expected 1", busy);
        end
        wait_done(1'b0, 100, lat);
        checks++;
        if (lat !== LAT_EXP) begin
            errors++;
            $display("FAIL basic_latency: got %0d expected %0d", lat, LAT_EXP);
        end
        checks++;
        if (wr_cnt - w0 !== 6) begin
            errors++;
            $display("FAIL basic_write_count: got %0d expected 6", wr_cnt - w0);
        end
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 3; c++) begin
                exp = (g[r] + SL * r) * MUL[c];
                checks++;
                if (wr_rows[r][c] !== 19'(exp)) begin
                    errors++;
                    $display("FAIL basic_row%0d_col%0d: got %0d expected %0d", r, c, wr_rows[r][c], exp);
                end
            end
        end
    endtask

    task automatic test_out_of_range();
        int g [6] = '{0, 3, 1, 0, 5, 4};
        int lat;
        int exp;
        load_graph(1'b1);
        launch(1'b0);
        repeat (12) @(negedge clk);   // ACC of edge 2
        checks++;
        if (edge_error !== 1'b0) begin
            errors++;
            $display("FAIL oor_error_before: got %b expected 0", edge_error);
        end
        @(negedge clk);
        checks++;
        if (edge_error !== 1'b1) begin
            errors++;
            $display("FAIL oor_error_after_acc: got %b expected 1", edge_error);
        end
        wait_done(1'b0, 100, lat);
        checks++;
        if (lat < 0 || edge_error !== 1'b1) begin
            errors++;
            $display("FAIL oor_error_at_done: got lat=%0d err=%b expected err=1", lat, edge_error);
        end
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 3; c++) begin
                exp = (g[r] + SL * r) * MUL[c];
                checks++;
                if (wr_rows[r][c] !== 19'(exp)) begin
                    errors++;
                    $display("FAIL oor_row%0d_col%0d: got %0d expected %0d", r, c, wr_rows[r][c], exp);
                end
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (edge_error !== 1'b1) begin
            errors++;
            $display("FAIL oor_error_sticky_idle: got %b expected 1", edge_error);
        end
    endtask

    task automatic test_start_ignored();
        int lat;
        int w0;
        int d0;
        load_graph(1'b0);
        w0 = wr_cnt;
        d0 = done_cnt;
        launch(1'b0);
        @(negedge clk);               // COO_REQ of edge 0, after CLR
        checks++;
        if (edge_error !== 1'b0) begin
            errors++;
            $display("FAIL start_error_cleared: got %b expected 0", edge_error);
        end
        repeat (12) @(negedge clk);   // COO_REQ of edge 3
        checks++;
        if ({enable_read, read_address} !== {1'b1, 13'h403}) begin
            errors++;
            $display("FAIL start_coo_req_edge3: got en=%b addr=%h expected en=1 addr=403", enable_read, read_address);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1'b0, 100, lat);
        repeat (40) @(negedge clk);
        checks++;
        if (wr_cnt - w0 !== 6) begin
            errors++;
            $display("FAIL start_write_count: got %0d expected 6", wr_cnt - w0);
        end
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL start_done_count: got %0d expected 1", done_cnt - d0);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_idle_after: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid_run();
        bit found;
        load_graph(1'b0);
        launch(1'b0);
        found = 1'b0;
        for (int m = 0; m < 100; m++) begin
            if (agg_wr_en === 1'b1 && agg_write_row === 3'd2) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midreset_reach_row2: got timeout expected write of row 2");
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (outs_flat !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got %h expected 0", outs_flat);
        end
        reset = 1'b1;
        @(negedge clk);
        test_basic();
    endtask

    task automatic test_wrap();
        int lat;
        logic [16:0] exp0;
        logic [16:0] exp_other;
        for (int i = 0; i < 6; i++) coo_tab[i] = {8'd0, 8'(i)};
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 3; c++) fm_tab[r][c] = 16'hFFFF;
        // 6 * 0xFFFF = 0x5FFFA -> 0x1FFFA; with self loops 7 * 0xFFFF = 0x6FFF9 -> 0x0FFF9
        exp0      = (SL == 1) ? 17'h0FFF9 : 17'h1FFFA;
        exp_other = (SL == 1) ? 17'h0FFFF : 17'h00000;
        launch(1'b1);
        wait_done(1'b1, 100, lat);
        checks++;
        if (lat !== LAT_EXP) begin
            errors++;
            $display("FAIL wrap_latency: got %0d expected %0d", lat, LAT_EXP);
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (wr_rows_w[0][c] !== exp0) begin
                errors++;
                $display("FAIL wrap_row0_col%0d: got %h expected %h", c, wr_rows_w[0][c], exp0);
            end
        end
        for (int r = 1; r < 6; r++) begin
            checks++;
            if (wr_rows_w[r][0] !== exp_other) begin
                errors++;
                $display("FAIL wrap_row%0d: got %h expected %h", r, wr_rows_w[r][0], exp_other);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_out_of_range();
        test_start_ignored();
        test_reset_mid_run();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_aggregation_block
